// File: rtl/relm_uart_pkg.sv
// Shared constants and state encodings for the relm_uart codebase slice.
package relm_uart_pkg;

  // ctl_d command bits, as offsets below the strobe bit (bit WD)
  localparam int unsigned CTL_POP_OFS  = 1;
  localparam int unsigned CTL_LOAD_OFS = 2;
  localparam int unsigned CTL_CLR_OFS  = 3;

  // ctl_q status bits, as offsets below bit WD
  localparam int unsigned STS_TXNF_OFS = 1;
  localparam int unsigned STS_RXNE_OFS = 2;
  localparam int unsigned STS_OVR_OFS  = 3;
  localparam int unsigned STS_FRM_OFS  = 4;

  // ctl_q absolute fields
  localparam int unsigned STS_CNT_LSB  = 8;
  localparam int unsigned STS_CNT_MSB  = 15;
  localparam int unsigned STS_HEAD_MSB = 7;

  // Smallest divisor the engines accept
  localparam int unsigned DIV_MIN       = 4;
  localparam int unsigned BITS_PER_CHAR = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/relm_uart_fifo.sv
// First-word-fall-through byte FIFO, depth 2**WAF, with full/empty/count.
module relm_uart_fifo #(
  parameter int unsigned WAF = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [7:0]   wr_data,
  input  logic         rd_en,
  output logic [7:0]   rd_data,
  output logic         full,
  output logic         empty,
  output logic [WAF:0] count
);

  localparam int unsigned DEPTH = 1 << WAF;
  localparam logic [WAF:0] FULL_CNT = {1'b1, {WAF{1'b0}}};

  logic [7:0]     mem_q [DEPTH];
  logic [WAF-1:0] wptr_q, wptr_d;
  logic [WAF-1:0] rptr_q, rptr_d;
  logic [WAF:0]   count_q, count_d;
  logic           do_wr, do_rd;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];

  // Pointer and occupancy update; writes to full and reads from empty are ignored
  always_comb begin
    do_wr   = wr_en && !full;
    do_rd   = rd_en && !empty;
    wptr_d  = do_wr ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_rd ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    if (do_rd && !do_wr) count_d = count_q - 1'b1;
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/relm_uart.sv
// 8N1 UART with TX/RX byte FIFOs, programmable baud divisor and sticky error flags.
module relm_uart
  import relm_uart_pkg::*;
#(
  parameter int unsigned WD       = 32,
  parameter int unsigned WAF      = 4,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DIV_INIT = 434
) (
  input  logic        clk,
  input  logic        rst_n_in,
  input  logic        uart_in,
  output logic        uart_out,
  input  logic [WD:0] tx_d,
  output logic        tx_retry,
  input  logic [WD:0] ctl_d,
  output logic [WD:0] ctl_q
);

  localparam logic [DIV_W-1:0] DIV_INIT_C = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] DIV_MIN_C  = DIV_W'(DIV_MIN);
  localparam logic [2:0]       LAST_BIT   = 3'(BITS_PER_CHAR - 1);

  // control decode
  logic             ctl_pop, ctl_load, ctl_clr;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ovr_q, ovr_d, frm_q, frm_d;

  // fifos
  logic         tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]   tx_head;
  logic [WAF:0] tx_count;
  logic         rx_wr, rx_full, rx_empty;
  logic [7:0]   rx_head;
  logic [WAF:0] rx_count;

  // transmitter
  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             uart_out_q, uart_out_d;
  logic             tx_last;

  // receiver
  logic             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_fall, rx_last, rx_half, frm_set, ovr_set;

  logic unused_bits;
  assign unused_bits = ^{tx_d[WD-1:8], ctl_d[WD-4:DIV_W], tx_count};

  assign tx_push  = tx_d[WD] & ~tx_full;
  assign tx_retry = tx_full;
  assign uart_out = uart_out_q;

  relm_uart_fifo #(.WAF(WAF)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n_in),
    .wr_en   (tx_push),
    .wr_data (tx_d[7:0]),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  relm_uart_fifo #(.WAF(WAF)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n_in),
    .wr_en   (rx_wr),
    .wr_data (rx_sh_q),
    .rd_en   (ctl_pop),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // Command decode, divisor load with clamping, sticky flags (set wins over clear)
  always_comb begin
    ctl_pop  = ctl_d[WD] & ctl_d[WD-CTL_POP_OFS];
    ctl_load = ctl_d[WD] & ctl_d[WD-CTL_LOAD_OFS];
    ctl_clr  = ctl_d[WD] & ctl_d[WD-CTL_CLR_OFS];
    div_d    = div_q;
    if (ctl_load) div_d = (ctl_d[DIV_W-1:0] < DIV_MIN_C) ? DIV_MIN_C : ctl_d[DIV_W-1:0];
    ovr_set  = rx_wr & rx_full;
    ovr_d    = (ovr_q & ~ctl_clr) | ovr_set;
    frm_d    = (frm_q & ~ctl_clr) | frm_set;
    sync1_d  = uart_in;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
  end

  // Status word
  always_comb begin
    ctl_q                          = '0;
    ctl_q[WD-STS_TXNF_OFS]         = ~tx_full;
    ctl_q[WD-STS_RXNE_OFS]         = ~rx_empty;
    ctl_q[WD-STS_OVR_OFS]          = ovr_q;
    ctl_q[WD-STS_FRM_OFS]          = frm_q;
    ctl_q[STS_CNT_MSB:STS_CNT_LSB] = 8'(rx_count);
    ctl_q[STS_HEAD_MSB:0]          = rx_empty ? 8'h00 : rx_head;
  end

  // Divisor, flags and input synchroniser registers
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q   <= DIV_INIT_C;
      ovr_q   <= 1'b0;
      frm_q   <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      ovr_q   <= ovr_d;
      frm_q   <= frm_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  // TX state register
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_INIT_C;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      uart_out_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      uart_out_q <= uart_out_d;
    end
  end

  // TX next state; the divisor is latched only when a frame starts
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    tx_last    = (tx_cnt_q == tx_div_q - 1'b1);
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_state_d = TX_START;
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_div_d   = div_q;
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          end
        end
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_state_d = TX_START;
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_div_d   = div_q;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
    endcase
  end

  // TX line level, decoded from the state being entered so the pin is registered
  always_comb begin
    unique case (tx_state_d)
      TX_START: uart_out_d = 1'b0;
      TX_DATA:  uart_out_d = tx_sh_d[0];
      default:  uart_out_d = 1'b1;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_INIT_C;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // RX next state; a start needs a falling edge, so a low line after a bad stop never re-arms
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_fall    = sync3_q & ~sync2_q;
    rx_last    = (rx_cnt_q == rx_div_q - 1'b1);
    rx_half    = (rx_cnt_q == (rx_div_q >> 1) - 1'b1);
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_div_d   = div_q;
        end
      end
      RX_START: begin
        if (rx_half) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_last) begin
          rx_cnt_d = '0;
          rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end
      end
    endcase
  end

  // RX outputs: FIFO write on a good stop bit, framing error on a bad one
  always_comb begin
    rx_wr   = 1'b0;
    frm_set = 1'b0;
    if (rx_state_q == RX_STOP && rx_last) begin
      rx_wr   = sync2_q;
      frm_set = ~sync2_q;
    end
  end

endmodule

// File: tb/tb_relm_uart.sv
// Self-checking bench for relm_uart: directed sequence with random payloads.
module tb_relm_uart;

  localparam logic [32:0] CTL_RST = 33'h1 << 31;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        uart_in, uart_out, tx_retry;
  logic [32:0] tx_d, ctl_d, ctl_q;
  logic        line_drv, loop_en;

  int total = 0;
  int bad   = 0;

  bit         exp_q[$];
  logic [7:0] push_q[$];
  bit         line_q[$];
  logic [7:0] rx_model[$];
  logic [7:0] data[17];

  assign uart_in = loop_en ? uart_out : line_drv;

  always #5 clk = ~clk;

  relm_uart #(
    .WD       (32),
    .WAF      (4),
    .DIV_W    (16),
    .DIV_INIT (434)
  ) dut (
    .clk      (clk),
    .rst_n_in (rst_n_in),
    .uart_in  (uart_in),
    .uart_out (uart_out),
    .tx_d     (tx_d),
    .tx_retry (tx_retry),
    .ctl_d    (ctl_d),
    .ctl_q    (ctl_q)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [32:0] mk_ctl(input logic pop, input logic ld, input logic clr,
                                         input logic [15:0] dv);
    logic [32:0] r;
    r = '0;
    r[32] = 1'b1;
    r[31] = pop;
    r[30] = ld;
    r[29] = clr;
    r[15:0] = dv;
    return r;
  endfunction

  function automatic logic [32:0] mk_push(input logic [7:0] b);
    return {1'b1, 24'h0, b};
  endfunction

  // expected TX line: start, 8 data bits LSB first, stop, each held d clocks
  task automatic add_tx_frame(input logic [7:0] b, input int d);
    for (int k = 0; k < d; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < d; k++) exp_q.push_back(b[i]);
    for (int k = 0; k < d; k++) exp_q.push_back(1'b1);
  endtask

  task automatic add_ones(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(1'b1);
  endtask

  // stimulus line for the receiver, with a short idle gap after the frame
  task automatic add_line_frame(input logic [7:0] b, input logic stop, input int d);
    for (int k = 0; k < d; k++) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < d; k++) line_q.push_back(b[i]);
    for (int k = 0; k < d; k++) line_q.push_back(stop);
    line_q.push_back(1'b1);
    line_q.push_back(1'b1);
  endtask

  task automatic run_line();
    while (line_q.size() > 0) begin
      line_drv = line_q.pop_front();
      step();
    end
    line_drv = 1'b1;
  endtask

  // clock through the expected TX waveform, pushing queued bytes one per cycle
  task automatic tx_watch(input int retry_at, input int ld_at, input logic [15:0] ld_val);
    int  j;
    bit  want;
    j = 0;
    while (exp_q.size() > 0) begin
      tx_d  = '0;
      ctl_d = '0;
      if (push_q.size() > 0) begin
        tx_d = mk_push(push_q.pop_front());
        chk("tx_retry", tx_retry, (j == retry_at));
      end
      if (j == ld_at) ctl_d = mk_ctl(1'b0, 1'b1, 1'b0, ld_val);
      step();
      want = exp_q.pop_front();
      chk("uart_out", uart_out, want);
      j++;
    end
    tx_d  = '0;
    ctl_d = '0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp, input logic also);
    ctl_d = mk_ctl(1'b1, also, also, 16'd4);
    #1;
    chk(tag, ctl_q[7:0], exp);
    step();
    ctl_d = '0;
  endtask

  int         seen;
  logic [7:0] b;

  initial begin
    rst_n_in = 1'b0;
    tx_d     = '0;
    ctl_d    = '0;
    line_drv = 1'b1;
    loop_en  = 1'b0;

    // reset values
    #12;
    chk("rst_uart_out", uart_out, 1'b1);
    chk("rst_tx_retry", tx_retry, 1'b0);
    chk("rst_ctl_q", ctl_q, CTL_RST);
    #21 rst_n_in = 1'b1;
    step_n(4);
    chk("post_rst_ctl_q", ctl_q, CTL_RST);

    ctl_d = mk_ctl(1'b0, 1'b1, 1'b0, 16'd4);
    step();
    ctl_d = '0;

    // single frame 0xA5 at divisor 4
    tx_d = mk_push(8'hA5);
    step();
    tx_d = '0;
    chk("a5_idle", uart_out, 1'b1);
    add_tx_frame(8'hA5, 4);
    add_ones(4);
    tx_watch(-1, -1, 16'd0);

    // fill TX FIFO while a frame is in flight; 17th push refused
    b = 8'($urandom);
    tx_d = mk_push(b);
    step();
    tx_d = '0;
    chk("fill_idle", uart_out, 1'b1);
    add_tx_frame(b, 4);
    for (int i = 0; i < 17; i++) begin
      data[i] = 8'($urandom);
      push_q.push_back(data[i]);
      if (i < 16) add_tx_frame(data[i], 4);
    end
    add_ones(8);
    tx_watch(16, -1, 16'd0);
    chk("fill_txnf", ctl_q[31], 1'b1);

    // divisor change mid-frame: 8 now, 2 (clamped to 4) from next frame
    ctl_d = mk_ctl(1'b0, 1'b1, 1'b0, 16'd8);
    step();
    ctl_d = '0;
    b = 8'($urandom);
    tx_d = mk_push(b);
    step();
    tx_d = '0;
    chk("div_idle", uart_out, 1'b1);
    add_tx_frame(b, 8);
    b = 8'($urandom);
    push_q.push_back(b);
    add_tx_frame(b, 4);
    add_ones(8);
    tx_watch(-1, 20, 16'd2);

    // loopback: fixed bytes then random ones
    loop_en = 1'b1;
    data[0] = 8'h00;
    data[1] = 8'hFF;
    data[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tx_d = mk_push(data[i]);
      step();
    end
    tx_d = '0;
    step_n(140);
    chk("lb_occ", ctl_q[15:8], 8'd3);
    chk("lb_rxne", ctl_q[30], 1'b1);
    for (int i = 0; i < 3; i++) pop_chk("lb_pop", data[i], 1'b0);
    chk("lb_rxne_clr", ctl_q[30], 1'b0);
    chk("lb_head_empty", ctl_q[7:0], 8'h00);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      rx_model.push_back(b);
      tx_d = mk_push(b);
      step();
    end
    tx_d = '0;
    step_n(180);
    chk("lb_rand_occ", ctl_q[15:8], 8'(rx_model.size()));
    while (rx_model.size() > 0) pop_chk("lb_rand_pop", rx_model.pop_front(), 1'b0);
    loop_en = 1'b0;

    // glitch shorter than half a bit is rejected
    line_q.push_back(1'b0);
    for (int k = 0; k < 12; k++) line_q.push_back(1'b1);
    run_line();
    step_n(4);
    chk("glitch_occ", ctl_q[15:8], 8'd0);
    chk("glitch_flags", ctl_q[29:28], 2'b00);

    // framing error: stop bit 0
    add_line_frame(8'($urandom), 1'b0, 4);
    run_line();
    step_n(8);
    chk("frm_flag", ctl_q[28], 1'b1);
    chk("frm_occ", ctl_q[15:8], 8'd0);
    chk("frm_ovr", ctl_q[29], 1'b0);
    ctl_d = mk_ctl(1'b0, 1'b0, 1'b1, 16'd0);
    step();
    ctl_d = '0;
    chk("frm_clr", ctl_q[28], 1'b0);

    // overrun: 17 frames into a 16-deep RX FIFO
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (rx_model.size() < 16) rx_model.push_back(b);
      add_line_frame(b, 1'b1, 4);
    end
    run_line();
    step_n(8);
    chk("ovr_occ", ctl_q[15:8], 8'd16);
    chk("ovr_flag", ctl_q[29], 1'b1);
    chk("ovr_head", ctl_q[7:0], rx_model[0]);
    chk("ovr_txnf", ctl_q[31], 1'b1);

    // clear held while an 18th frame overruns: the new error must win
    add_line_frame(8'($urandom), 1'b1, 4);
    ctl_d = mk_ctl(1'b0, 1'b0, 1'b1, 16'd0);
    seen = -1;
    for (int i = 0; i < 80; i++) begin
      line_drv = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
      step();
      if (i == 0) chk("ovr_cleared", ctl_q[29], 1'b0);
      if (ctl_q[29] == 1'b1) begin
        seen = i;
        break;
      end
    end
    ctl_d = '0;
    chk("ovr_set_wins", (seen > 0), 1'b1);
    run_line();
    step_n(2);
    chk("ovr_sticky", ctl_q[29], 1'b1);
    chk("ovr_occ2", ctl_q[15:8], 8'd16);
    chk("ovr_head2", ctl_q[7:0], rx_model[0]);

    // pop + load + clear in one word, then drain the rest
    pop_chk("ovr_pop0", rx_model.pop_front(), 1'b1);
    chk("combo_ovr", ctl_q[29], 1'b0);
    chk("combo_occ", ctl_q[15:8], 8'd15);
    while (rx_model.size() > 0) pop_chk("ovr_pop", rx_model.pop_front(), 1'b0);
    chk("ovr_drained", ctl_q[30], 1'b0);

    // reset in the middle of a loopback transfer
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_d = mk_push(8'h00);
      step();
    end
    tx_d = '0;
    step_n(57);
    chk("mid_line_low", uart_out, 1'b0);
    chk("mid_occ", ctl_q[15:8], 8'd1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("mid_rst_uart_out", uart_out, 1'b1);
    chk("mid_rst_retry", tx_retry, 1'b0);
    chk("mid_rst_ctl_q", ctl_q, CTL_RST);
    step_n(2);
    #3 rst_n_in = 1'b1;
    step_n(30);
    chk("post_mid_ctl_q", ctl_q, CTL_RST);
    chk("post_mid_uart_out", uart_out, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/relm_uart.md
RELM_UART -- requirements
Module: relm_uart

Interface
REQ-001 SHALL take parameter WD, default 32: data path width; push/pop words are WD+1 bits, and bit WD is the strobe.
REQ-002 SHALL take parameter WAF, default 4: FIFO address width, so each of the TX and RX FIFOs holds 2**WAF bytes.
REQ-003 SHALL take parameter DIV_W, default 16: width of the baud divisor.
REQ-004 SHALL take parameter DIV_INIT, default 434: clocks per bit after reset (50 MHz / 115200).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port uart_in, input, 1 bit: serial receive line, idle high, asynchronous to clk.
REQ-008 SHALL have port uart_out, output, 1 bit: serial transmit line, idle high, registered.
REQ-009 SHALL have port tx_d, input, WD+1 bits: bit WD pushes byte [7:0] into the TX FIFO.
REQ-010 SHALL have port tx_retry, output, 1 bit: TX FIFO full; a push in this cycle is refused.
REQ-011 SHALL have port ctl_d, input, WD+1 bits: bit WD is the strobe; with the strobe set, WD-1 pops RX, WD-2 loads the divisor from [DIV_W-1:0], and WD-3 clears the error flags.
REQ-012 SHALL have port ctl_q, output, WD+1 bits: WD=0; WD-1=TX not full; WD-2=RX not empty; WD-3=overrun; WD-4=framing error; [15:8]=RX occupancy (zero-extended); [7:0]=RX head byte (0 when empty); all other bits 0.

Function
REQ-013 SHALL pass uart_in through a 2-flop synchroniser initialised to 1 before any use.
REQ-014 SHALL clamp a loaded divisor below 4 to 4; a new divisor SHALL apply only at the next frame start of each direction, never mid-frame.
REQ-015 SHALL run the TX FSM as IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
REQ-016 In TX, each state SHALL hold for exactly divisor clocks; data SHALL go LSB first; frame is 8N1.
REQ-017 In TX IDLE, when the TX FIFO is non-empty, the FSM SHALL pop the head and drive uart_out=0 on the next edge.
REQ-018 Back-to-back TX frames SHALL have no idle gap: STOP is followed directly by START if the FIFO is non-empty.
REQ-019 SHALL run the RX FSM as IDLE -> START -> DATA -> STOP.
REQ-020 RX IDLE SHALL go to START on a synchronised 1->0 transition.
REQ-021 In RX START, the FSM SHALL sample at divisor/2 (integer division); if the line is high there, it SHALL return to IDLE (glitch rejected, nothing written).
REQ-022 In RX DATA, each of the 8 bits SHALL be sampled every divisor clocks thereafter.
REQ-023 In RX STOP, the FSM SHALL sample one divisor later. Stop=1: write the byte to the RX FIFO. Stop=0: set the framing flag, discard the byte, and wait in IDLE for the line to return high before re-arming.
REQ-024 An RX write into a full RX FIFO SHALL drop the byte and set the overrun flag; FIFO contents are unchanged.
REQ-025 A tx_d push is accepted iff tx_retry=0 in that cycle.
REQ-026 tx_retry SHALL be derived from the registered count; a simultaneous transmitter pop does not unblock a push in the same cycle.
REQ-027 The RX head is shown on ctl_q in the same cycle as the pop strobe; the pop takes effect on that edge. Popping an empty FIFO SHALL be ignored.
REQ-028 A simultaneous RX write and pop on a non-full FIFO SHALL both succeed, with the count unchanged.
REQ-029 Error flags are sticky until cleared by WD-3. A clear in the same cycle as a new error SHALL leave the flag set.
REQ-030 Pop, divisor load and clear in one ctl_d word SHALL all be performed in that cycle.
REQ-031 FIFO pointers SHALL wrap modulo 2**WAF; occupancy SHALL be WAF+1 bits wide.

Reset
REQ-032 While rst_n_in=0: uart_out=1, tx_retry=0, both FSMs IDLE, both FIFOs empty, flags 0, divisor=DIV_INIT, synchroniser=11, ctl_q = {0, 1, 0, 0, 0, 0...}.
REQ-033 Reset asserted mid-frame SHALL abort immediately: TX line high, any partial RX byte discarded.
REQ-034 Reset release SHALL not by itself cause any RX start detection.

Structure
REQ-035 ctl_d/ctl_q bit-position constants and the FSM state encodings SHALL live in a shared package, relm_uart_pkg.
REQ-036 One sub-module, relm_uart_fifo (first-word-fall-through, depth 2**WAF, 8-bit, full/empty/count), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-037 Divisor 4; push 0xA5 -> uart_out shows 0,1,0,1,0,0,1,0,1,1 with each bit held 4 clocks, START 1 clock after push.
REQ-038 Push 17 bytes with no drain at WAF=4 -> byte 17 refused; tx_retry=1 while count=16; then 16 frames transmitted back-to-back, no gaps.
REQ-039 Loop uart_out to uart_in, send 0x00,0xFF,0x3C -> RX occupancy 3; three pops return 0x00,0xFF,0x3C; RX not-empty clears after the third pop.
REQ-040 RX low pulse of divisor/4 -> nothing written, flags 0; frame with stop bit 0 -> framing flag 1, occupancy unchanged.
REQ-041 Receive 17 bytes without popping -> occupancy 16, overrun=1, head = first byte; clear and new overrun in the same cycle -> overrun stays 1.
REQ-042 Load divisor 2 mid-frame at divisor 8 -> current frame finishes at 8 clocks/bit, next frame at 4; rst_n_in pulsed mid-frame -> uart_out=1 at once, FIFOs empty.
